// File: rtl/axicb_arb_pkg.sv
// rtl/axicb_arb_pkg.sv - shared types and width helper for the QoS crossbar arbiter
package axicb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Ceiling log2 that never returns less than 1, so single-value fields still get a bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axicb_rr_pick.sv
// rtl/axicb_rr_pick.sv - rotating-priority picker: first request at or after start, wrapping
module axicb_rr_pick #(
    parameter int REQ_NB = 4,
    parameter int IDX_W  = 2
) (
    input  logic [REQ_NB-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [REQ_NB-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic              found
);

    int               cand_i;
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand_i = 0;
        cand   = '0;
        for (int k = 0; k < REQ_NB; k++) begin
            cand_i = (int'(start) + k) % REQ_NB;
            cand   = IDX_W'(cand_i);
            if (!found && req[cand]) begin
                found        = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axicb_qos_arbiter.sv
// rtl/axicb_qos_arbiter.sv - QoS arbiter with per-level round robin, grant lock and starvation aging
module axicb_qos_arbiter
    import axicb_arb_pkg::*;
#(
    parameter int REQ_NB  = 4,
    parameter int PRIO_NB = 4,
    parameter int PRIO_W  = clog2_min1(PRIO_NB),
    parameter int AGE_W   = 4,
    parameter int AGE_MAX = 8,
    localparam int ID_W   = clog2_min1(REQ_NB)
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     en,
    input  logic [REQ_NB-1:0]        req,
    input  logic [REQ_NB*PRIO_W-1:0] req_prio,
    input  logic                     done,
    output logic [REQ_NB-1:0]        grant,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    // Level PRIO_NB is the starved level, reachable only through aging
    localparam int               LVL_NB   = PRIO_NB + 1;
    localparam int               LVL_W    = clog2_min1(LVL_NB);
    localparam logic [AGE_W-1:0] AGE_TOP  = AGE_W'(AGE_MAX);
    localparam bit               AGING_ON = (AGE_MAX != 0);

    arb_state_t        state;
    arb_state_t        state_nxt;

    logic [AGE_W-1:0]  age      [REQ_NB];
    logic [ID_W-1:0]   ptr      [LVL_NB];
    logic [LVL_W-1:0]  eff_lvl  [REQ_NB];
    logic [REQ_NB-1:0] lvl_req  [LVL_NB];
    logic [REQ_NB-1:0] lvl_gnt  [LVL_NB];
    logic [ID_W-1:0]   lvl_idx  [LVL_NB];
    logic [LVL_NB-1:0] lvl_found;

    logic              win_found;
    logic [LVL_W-1:0]  win_lvl;
    logic [ID_W-1:0]   win_idx;
    logic [REQ_NB-1:0] win_gnt;
    logic [ID_W-1:0]   win_ptr_nxt;
    logic              arb_fire;
    logic              arb_release;

    always_comb begin
        for (int i = 0; i < REQ_NB; i++) begin
            if (int'(req_prio[i*PRIO_W +: PRIO_W]) >= PRIO_NB) begin
                eff_lvl[i] = LVL_W'(PRIO_NB - 1);
            end else begin
                eff_lvl[i] = LVL_W'(req_prio[i*PRIO_W +: PRIO_W]);
            end
            if (AGING_ON && (age[i] == AGE_TOP)) begin
                eff_lvl[i] = LVL_W'(PRIO_NB);
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LVL_NB; l++) begin
            for (int i = 0; i < REQ_NB; i++) begin
                lvl_req[l][i] = req[i] && (int'(eff_lvl[i]) == l);
            end
        end
    end

    for (genvar l = 0; l < LVL_NB; l++) begin : g_lvl
        axicb_rr_pick #(
            .REQ_NB (REQ_NB),
            .IDX_W  (ID_W)
        ) u_pick (
            .req    (lvl_req[l]),
            .start  (ptr[l]),
            .onehot (lvl_gnt[l]),
            .idx    (lvl_idx[l]),
            .found  (lvl_found[l])
        );
    end

    // Ascending scan: the last level with a request is the highest one
    always_comb begin
        win_found = 1'b0;
        win_lvl   = '0;
        win_idx   = '0;
        win_gnt   = '0;
        for (int l = 0; l < LVL_NB; l++) begin
            if (lvl_found[l]) begin
                win_found = 1'b1;
                win_lvl   = LVL_W'(l);
                win_idx   = lvl_idx[l];
                win_gnt   = lvl_gnt[l];
            end
        end
        win_ptr_nxt = (int'(win_idx) == REQ_NB - 1) ? '0 : win_idx + ID_W'(1);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (en && win_found) state_nxt = ARB_BUSY;
            ARB_BUSY: if (done)            state_nxt = ARB_IDLE;
            default:                       state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == ARB_BUSY);
        arb_fire    = (state == ARB_IDLE) && en && win_found;
        arb_release = (state == ARB_BUSY) && done;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            grant    <= '0;
            grant_id <= '0;
        end else if (arb_fire) begin
            grant    <= win_gnt;
            grant_id <= win_idx;
        end else if (arb_release) begin
            grant    <= '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int l = 0; l < LVL_NB; l++) begin
                ptr[l] <= '0;
            end
        end else if (arb_fire) begin
            for (int l = 0; l < LVL_NB; l++) begin
                if (l == int'(win_lvl)) begin
                    ptr[l] <= win_ptr_nxt;
                end
            end
        end
    end

    // Losers that are still requesting age toward the starved level; idle requesters keep their age
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < REQ_NB; i++) begin
                age[i] <= '0;
            end
        end else if (arb_fire) begin
            for (int i = 0; i < REQ_NB; i++) begin
                if (i == int'(win_idx)) begin
                    age[i] <= '0;
                end else if (req[i] && (age[i] != AGE_TOP)) begin
                    age[i] <= age[i] + AGE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_axicb_qos_arbiter.sv
// tb/tb_axicb_qos_arbiter.sv - scoreboard bench for axicb_qos_arbiter with and without aging
module tb_axicb_qos_arbiter;

    typedef struct {
        logic [3:0] g;
        int         at;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       done  = 1'b0;
    logic [3:0] req   = '0;
    logic [7:0] prio  = '0;

    logic [3:0] grant_a, grant_b;
    logic [1:0] id_a, id_b;
    logic       busy_a, busy_b;

    int   cyc     = 0;
    int   n_total = 0;
    int   n_pass  = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic prev_a  = 1'b0;
    logic prev_b  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axicb_qos_arbiter #(.REQ_NB(4), .PRIO_NB(4), .AGE_W(4), .AGE_MAX(2)) dut_a (
        .aclk     (clk),
        .areset   (rst),
        .en       (en),
        .req      (req),
        .req_prio (prio),
        .done     (done),
        .grant    (grant_a),
        .grant_id (id_a),
        .busy     (busy_a)
    );

    axicb_qos_arbiter #(.REQ_NB(4), .PRIO_NB(4), .AGE_W(4), .AGE_MAX(0)) dut_b (
        .aclk     (clk),
        .areset   (rst),
        .en       (en),
        .req      (req),
        .req_prio (prio),
        .done     (done),
        .grant    (grant_b),
        .grant_id (id_b),
        .busy     (busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] idx_of(input logic [3:0] oh);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

    task automatic expect_both(input logic [3:0] ga, input logic [3:0] gb, input int at);
        exp_t e;
        e.g = ga; e.at = at; q_a.push_back(e);
        e.g = gb; e.at = at; q_b.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        en   = 1'b0;
        done = 1'b0;
        prio = '0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
    endtask

    // Expected grants packed low nibble first; done pulses the cycle after each grant
    task automatic grant_train(input logic [23:0] ga, input logic [23:0] gb, input int n);
        expect_both(ga[3:0], gb[3:0], cyc + 1);
        @(negedge clk);
        for (int k = 1; k < n; k++) begin
            done = 1'b1;
            expect_both(ga[k*4 +: 4], gb[k*4 +: 4], cyc + 2);
            @(negedge clk);
            done = 1'b0;
            @(negedge clk);
        end
        done = 1'b1;
        req  = '0;
        @(negedge clk);
        done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && busy_a && !prev_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_grant", {28'd0, grant_a}, 32'd0);
            end else begin
                ea = q_a.pop_front();
                chk("a_grant", {28'd0, grant_a}, {28'd0, ea.g});
                chk("a_grant_id", {30'd0, id_a}, idx_of(ea.g));
                chk("a_grant_cycle", cyc, ea.at);
            end
        end
        prev_a = busy_a;
    end

    always @(negedge clk) begin
        if (!rst && busy_b && !prev_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_grant", {28'd0, grant_b}, 32'd0);
            end else begin
                eb = q_b.pop_front();
                chk("b_grant", {28'd0, grant_b}, {28'd0, eb.g});
                chk("b_grant_id", {30'd0, id_b}, idx_of(eb.g));
                chk("b_grant_cycle", cyc, eb.at);
            end
        end
        prev_b = busy_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_state_a", {25'd0, busy_a, id_a, grant_a}, 32'd0);
        chk("reset_state_b", {25'd0, busy_b, id_b, grant_b}, 32'd0);

        // equal priority round robin
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        grant_train(24'h018421, 24'h018421, 5);

        // fixed high priority on req3: aging on (a) vs off (b)
        do_reset();
        en   = 1'b1;
        prio = 8'b11_00_00_00;
        req  = 4'b1111;
        grant_train(24'h842188, 24'h888888, 6);

        // grant lock ignores req changes until done
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        expect_both(4'b0100, 4'b0100, cyc + 1);
        @(negedge clk);
        req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("lock_hold", {22'd0, busy_b, grant_b, busy_a, grant_a}, {22'd0, 10'b1_0100_1_0100});
        end
        done = 1'b1;
        expect_both(4'b0001, 4'b0001, cyc + 2);
        @(negedge clk);
        done = 1'b0;
        chk("release_idle", {22'd0, busy_b, grant_b, busy_a, grant_a}, 32'd0);
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(negedge clk);
        done = 1'b0;

        // en low blocks arbitration; done in IDLE is ignored
        do_reset();
        req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            done = (k == 2);
            @(negedge clk);
            chk("en_low_idle", {22'd0, busy_b, grant_b, busy_a, grant_a}, 32'd0);
        end
        done = 1'b0;
        en   = 1'b1;
        expect_both(4'b0001, 4'b0001, cyc + 1);
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(negedge clk);
        done = 1'b0;

        // asynchronous reset while busy, then pointers restart at 0
        do_reset();
        en   = 1'b1;
        prio = 8'b00_00_01_00;
        req  = 4'b0011;
        expect_both(4'b0010, 4'b0010, cyc + 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk("async_reset_drop", {22'd0, busy_b, grant_b, busy_a, grant_a}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        prio = '0;
        req  = 4'b1111;
        expect_both(4'b0001, 4'b0001, cyc + 1);
        @(negedge clk);
        done = 1'b1;
        req  = '0;
        @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);

        chk("queue_a_drained", q_a.size(), 32'd0);
        chk("queue_b_drained", q_b.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
